// File: rtl/l2cache_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache with tree-PLRU replacement.
// Define L2_PERF_CNT_EN to build the hit/miss/writeback performance counters.
module l2cache_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 8,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_adr,
    input  logic [LINE_W-1:0]   s_dat_m,
    input  logic [LINE_W/8-1:0] s_sel,
    input  logic                s_we,
    input  logic                s_stb,
    input  logic                s_cyc,
    output logic [LINE_W-1:0]   s_dat_s,
    output logic                s_ack,
    output logic                s_rty,
    output logic [ADDR_W-1:0]   m_adr,
    output logic [LINE_W-1:0]   m_dat_m,
    input  logic [LINE_W-1:0]   m_dat_s,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [LINE_W/8-1:0] m_sel,
    input  logic                m_ack,
    input  logic                hit_clr,
    input  logic                miss_clr,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int SEL_W  = LINE_W / 8;
    localparam int LVL    = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LVL : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {IDLE, TAG, DONE, WB, FILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [LINE_W-1:0]   wdat_q, wdat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                missed_q, missed_d;
    logic [WAY_W-1:0]    vict_q, vict_d;
    logic                s_ack_q, s_ack_d;
    logic [LINE_W-1:0]   s_dat_s_q, s_dat_s_d;
    logic [ADDR_W-1:0]   m_adr_q, m_adr_d;
    logic [LINE_W-1:0]   m_dat_m_q, m_dat_m_d;
    logic                m_cyc_q, m_cyc_d;
    logic                m_stb_q, m_stb_d;
    logic                m_we_q, m_we_d;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     valid_d [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAYS-1:0]     dirty_d [SETS];
    logic [PLRU_W-1:0]   plru_q  [SETS];
    logic [PLRU_W-1:0]   plru_d  [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];

    logic                data_we, tag_we;
    logic [WAY_W-1:0]    data_way;
    logic [LINE_W-1:0]   data_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    ltag;
    logic                hit, free;
    logic [WAY_W-1:0]    hit_way, free_way, vict;
    logic [LINE_W-1:0]   cur_line, new_line;
    logic                hit_inc, miss_inc, wb_inc;

    assign idx     = adr_q[IDX_W-1:0];
    assign ltag    = adr_q[ADDR_W-1:IDX_W];
    assign s_ack   = s_ack_q;
    assign s_dat_s = s_dat_s_q;
    assign s_rty   = s_stb & s_cyc & ~s_ack_q;
    assign m_adr   = m_adr_q;
    assign m_dat_m = m_dat_m_q;
    assign m_cyc   = m_cyc_q;
    assign m_stb   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_sel   = '1;

    // Tree bits: 0 sends the victim search left, 1 sends it right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) node = 2 * node + int'(bits[node-1]);
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0] way);
        logic [PLRU_W-1:0] r;
        int                node;
        logic              dir;
        r    = bits;
        node = 1;
        for (int l = 0; l < LVL; l++) begin
            dir       = way[LVL-1-l];
            r[node-1] = ~dir;
            node      = 2 * node + int'(dir);
        end
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] old_line,
                                                input logic [LINE_W-1:0] new_data,
                                                input logic [SEL_W-1:0] sel);
        logic [LINE_W-1:0] r;
        r = old_line;
        for (int b = 0; b < SEL_W; b++)
            if (sel[b]) r[b*8 +: 8] = new_data[b*8 +: 8];
        return r;
    endfunction

    // Descending scan so the lowest-index invalid way wins as the free slot.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == ltag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        vict     = free ? free_way : plru_victim(plru_q[idx]);
        cur_line = data_q[idx][hit_way];
        new_line = we_q ? merge(cur_line, wdat_q, sel_q) : cur_line;
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        missed_d  = missed_q;
        vict_d    = vict_q;
        s_ack_d   = 1'b0;
        s_dat_s_d = s_dat_s_q;
        m_adr_d   = m_adr_q;
        m_dat_m_d = m_dat_m_q;
        m_cyc_d   = m_cyc_q;
        m_stb_d   = m_stb_q;
        m_we_d    = m_we_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        plru_d    = plru_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        data_way  = vict_q;
        data_d    = m_dat_s;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        wb_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_stb && s_cyc) begin
                    adr_d    = s_adr;
                    wdat_d   = s_dat_m;
                    sel_d    = s_sel;
                    we_d     = s_we;
                    missed_d = 1'b0;
                    state_d  = TAG;
                end
            end
            TAG: begin
                if (hit) begin
                    if (we_q) begin
                        data_we               = 1'b1;
                        data_way              = hit_way;
                        data_d                = new_line;
                        dirty_d[idx][hit_way] = 1'b1;
                    end
                    s_dat_s_d   = new_line;
                    plru_d[idx] = plru_touch(plru_q[idx], hit_way);
                    hit_inc     = ~missed_q;
                    s_ack_d     = 1'b1;
                    state_d     = DONE;
                end else begin
                    miss_inc = ~missed_q;
                    missed_d = 1'b1;
                    vict_d   = vict;
                    m_cyc_d  = 1'b1;
                    m_stb_d  = 1'b1;
                    if (valid_q[idx][vict] && dirty_q[idx][vict]) begin
                        m_we_d    = 1'b1;
                        m_adr_d   = {tag_q[idx][vict], idx};
                        m_dat_m_d = data_q[idx][vict];
                        state_d   = WB;
                    end else begin
                        m_we_d  = 1'b0;
                        m_adr_d = adr_q;
                        state_d = FILL;
                    end
                end
            end
            DONE: state_d = IDLE;
            WB: begin
                if (m_ack) begin
                    dirty_d[idx][vict_q] = 1'b0;
                    wb_inc  = 1'b1;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    m_adr_d = adr_q;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Strobes drop for one cycle between the writeback and the fill.
                if (!m_cyc_q) begin
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                end else if (m_ack) begin
                    data_we              = 1'b1;
                    tag_we               = 1'b1;
                    valid_d[idx][vict_q] = 1'b1;
                    dirty_d[idx][vict_q] = 1'b0;
                    m_cyc_d              = 1'b0;
                    m_stb_d              = 1'b0;
                    state_d              = TAG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            missed_q  <= 1'b0;
            vict_q    <= '0;
            s_ack_q   <= 1'b0;
            s_dat_s_q <= '0;
            m_adr_q   <= '0;
            m_dat_m_q <= '0;
            m_cyc_q   <= 1'b0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= '0;
                dirty_q[i] <= '0;
                plru_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            missed_q  <= missed_d;
            vict_q    <= vict_d;
            s_ack_q   <= s_ack_d;
            s_dat_s_q <= s_dat_s_d;
            m_adr_q   <= m_adr_d;
            m_dat_m_q <= m_dat_m_d;
            m_cyc_q   <= m_cyc_d;
            m_stb_q   <= m_stb_d;
            m_we_q    <= m_we_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            plru_q    <= plru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx][data_way] <= data_d;
            if (tag_we) tag_q[idx][data_way] <= ltag;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    // Saturating counters; a clear overrides an increment in the same cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (hit_clr) hit_cnt_d = '0;
        else if (hit_inc && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
        if (miss_clr) miss_cnt_d = '0;
        else if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
        if (hit_clr || miss_clr) wb_cnt_d = '0;
        else if (wb_inc && (wb_cnt_q != '1)) wb_cnt_d = wb_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    logic unused_ok;
    assign unused_ok = ^{hit_clr, miss_clr, hit_inc, miss_inc, wb_inc};
    assign hit_cnt   = '0;
    assign miss_cnt  = '0;
    assign wb_cnt    = '0;
`endif

endmodule
